// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_run_ctrl
//  Purpose  : Run sequencer: resets the CPU, runs it for a cycle budget, then
//             freezes it and streams r0..r(NUM_DUMP-1) over a valid/ready port.
//  Options  : RUN_CTRL_EARLY_HALT_EN adds halt_i to end RUN early.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
   parameter int CNT_W      = 16,
   parameter int NUM_DUMP   = 12,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int RST_CYCLES = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
`ifdef RUN_CTRL_EARLY_HALT_EN
   input  logic              halt_i,
`endif
   input  logic              start_i,
   input  logic [CNT_W-1:0]  cycle_limit_i,
   output logic              cpu_rst_n_o,
   output logic              cpu_en_o,
   output logic [ADDR_W-1:0] dbg_raddr_o,
   input  logic [DATA_W-1:0] dbg_rdata_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [CNT_W-1:0]  run_cycles_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RST_W-1:0]  c_rst_last = RST_W'(RST_CYCLES - 1);
   localparam logic [ADDR_W-1:0] c_last_k   = ADDR_W'(NUM_DUMP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_RUN   = 3'd2,
      S_DUMP  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_limit;
   logic [RST_W-1:0]    r_rst_cnt;
   logic [CNT_W-1:0]    r_run_cnt;
   logic [CNT_W-1:0]    r_run_cycles;
   logic [ADDR_W-1:0]   r_k;
   logic                r_cpu_rst_n;
   logic                r_cpu_en;
   logic                r_dump_valid;
   logic                w_halt;
   logic                w_xfer;
   logic                w_accept;

`ifdef RUN_CTRL_EARLY_HALT_EN
   assign w_halt = halt_i;
`else
   assign w_halt = 1'b0;
`endif

   assign w_xfer   = r_dump_valid && dump_ready_i;
   assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_RESET;
         S_RESET: if (r_rst_cnt == c_rst_last)
                     w_next = (r_limit == '0) ? S_DUMP : S_RUN;
         S_RUN:   if (w_halt || (r_run_cnt == r_limit - 1'b1)) w_next = S_DUMP;
         S_DUMP:  if (w_xfer && (r_k == c_last_k)) w_next = S_DONE;
         S_DONE:  if (w_accept) w_next = S_RESET;
         default: w_next = S_IDLE;
      endcase
   end

   // Control outputs are decoded from the next state so they are registered
   // yet line up exactly with the state they belong to.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= S_IDLE;
         r_limit      <= '0;
         r_rst_cnt    <= '0;
         r_run_cnt    <= '0;
         r_run_cycles <= '0;
         r_k          <= '0;
         r_cpu_rst_n  <= 1'b0;
         r_cpu_en     <= 1'b0;
         r_dump_valid <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_cpu_rst_n  <= (w_next == S_RUN) || (w_next == S_DUMP) || (w_next == S_DONE);
         r_cpu_en     <= (w_next == S_RUN);
         r_dump_valid <= (w_next == S_DUMP);

         if (w_accept)
            r_limit <= cycle_limit_i;

         if (r_state == S_RESET)
            r_rst_cnt <= r_rst_cnt + 1'b1;
         else
            r_rst_cnt <= '0;

         if (r_state == S_RESET)
            r_run_cnt <= '0;
         else if (r_state == S_RUN)
            r_run_cnt <= r_run_cnt + 1'b1;

         if ((r_state == S_RUN) && (w_next == S_DUMP))
            r_run_cycles <= r_run_cnt + 1'b1;
         else if ((r_state == S_RESET) && (w_next == S_DUMP))
            r_run_cycles <= '0;

         if (r_state == S_RESET)
            r_k <= '0;
         else if ((r_state == S_DUMP) && w_xfer)
            r_k <= (r_k == c_last_k) ? '0 : r_k + 1'b1;
      end
   end

   assign cpu_rst_n_o  = r_cpu_rst_n;
   assign cpu_en_o     = r_cpu_en;
   assign dbg_raddr_o  = r_k;
   assign dump_addr_o  = r_k;
   assign dump_data_o  = dbg_rdata_i;
   assign dump_valid_o = r_dump_valid;
   assign run_cycles_o = r_run_cycles;
   assign busy_o       = (r_state == S_RESET) || (r_state == S_RUN) || (r_state == S_DUMP);
   assign done_o       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_run_ctrl
//  Purpose  : Directed table-driven bench for cpu_run_ctrl with a toy register
//             file standing in for the CPU (r_i gains i+1 per enabled cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

   localparam int CNT_W    = 16;
   localparam int NUM_DUMP = 12;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int MAX_CYC  = 2000;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              start_i;
   logic [CNT_W-1:0]  cycle_limit_i;
   logic              cpu_rst_n_o;
   logic              cpu_en_o;
   logic [ADDR_W-1:0] dbg_raddr_o;
   logic [DATA_W-1:0] dbg_rdata_i;
   logic              dump_valid_o;
   logic              dump_ready_i;
   logic [ADDR_W-1:0] dump_addr_o;
   logic [DATA_W-1:0] dump_data_o;
   logic [CNT_W-1:0]  run_cycles_o;
   logic              busy_o;
   logic              done_o;
`ifdef RUN_CTRL_EARLY_HALT_EN
   logic              halt_i;
`endif

   int n_cmp = 0;
   int n_err = 0;

   cpu_run_ctrl #(
      .CNT_W(CNT_W), .NUM_DUMP(NUM_DUMP), .DATA_W(DATA_W),
      .ADDR_W(ADDR_W), .RST_CYCLES(2)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
`ifdef RUN_CTRL_EARLY_HALT_EN
      .halt_i       (halt_i),
`endif
      .start_i      (start_i),
      .cycle_limit_i(cycle_limit_i),
      .cpu_rst_n_o  (cpu_rst_n_o),
      .cpu_en_o     (cpu_en_o),
      .dbg_raddr_o  (dbg_raddr_o),
      .dbg_rdata_i  (dbg_rdata_i),
      .dump_valid_o (dump_valid_o),
      .dump_ready_i (dump_ready_i),
      .dump_addr_o  (dump_addr_o),
      .dump_data_o  (dump_data_o),
      .run_cycles_o (run_cycles_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_i = ~clk_i;

   // Stand-in register file: cleared while the CPU is in reset, and each
   // enabled cycle adds i+1 to r_i (r0 stays zero).
   logic [DATA_W-1:0] rf [32];
   always @(posedge clk_i) begin
      for (int i = 0; i < 32; i++) begin
         if (!cpu_rst_n_o)
            rf[i] <= '0;
         else if (cpu_en_o && i != 0)
            rf[i] <= rf[i] + DATA_W'(i + 1);
      end
   end
   assign dbg_rdata_i = rf[dbg_raddr_o];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] exp_reg(input int k, input int n);
      return (k == 0) ? '0 : DATA_W'(n * (k + 1));
   endfunction

   function automatic logic ready_pat(input int mode, input int cyc);
      case (mode)
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         2:       return (cyc % 3 != 1);
         default: return 1'b1;
      endcase
   endfunction

   // One complete start..DONE transaction; poke re-pulses start mid-flight,
   // halt_at pulses halt_i (early-halt build only).
   task automatic run_one(input int lim, input int mode, input int poke,
                          input int halt_at, input int exp_run);
      int rst_cnt = 0, en_cnt = 0, beats = 0, cyc = 0;
      logic stalled = 1'b0;
      logic [ADDR_W-1:0] h_addr = '0;
      logic [DATA_W-1:0] h_data = '0;
      start_i       = 1'b1;
      cycle_limit_i = CNT_W'(lim);
      @(negedge clk_i);
      start_i = 1'b0;
      while (!done_o && cyc < MAX_CYC) begin
         if (busy_o && !cpu_rst_n_o) rst_cnt++;
         if (cpu_en_o) en_cnt++;
         start_i      = (cyc == poke);
         dump_ready_i = ready_pat(mode, cyc);
`ifdef RUN_CTRL_EARLY_HALT_EN
         halt_i = (cyc == halt_at);
`endif
         if (dump_valid_o) begin
            if (stalled) begin
               chk("stall_addr", 64'(dump_addr_o), 64'(h_addr));
               chk("stall_data", 64'(dump_data_o), 64'(h_data));
            end
            if (dump_ready_i) begin
               chk("beat_addr", 64'(dump_addr_o), 64'(beats));
               chk("beat_data", 64'(dump_data_o), 64'(exp_reg(beats, exp_run)));
               beats++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               h_addr  = dump_addr_o;
               h_data  = dump_data_o;
            end
         end
         @(negedge clk_i);
         cyc++;
      end
      start_i      = 1'b0;
      dump_ready_i = 1'b0;
`ifdef RUN_CTRL_EARLY_HALT_EN
      halt_i = 1'b0;
`else
      if (halt_at > 1000) $display("note: halt_at %0d ignored", halt_at);
`endif
      chk("timeout",    64'(cyc < MAX_CYC), 64'd1);
      chk("reset_len",  64'(rst_cnt), 64'd2);
      chk("en_cycles",  64'(en_cnt), 64'(exp_run));
      chk("beat_count", 64'(beats), 64'(NUM_DUMP));
      chk("run_cycles", 64'(run_cycles_o), 64'(exp_run));
      chk("done",       64'(done_o), 64'd1);
      chk("done_valid", 64'(dump_valid_o), 64'd0);
      chk("done_busy",  64'(busy_o), 64'd0);
      chk("done_rstn",  64'(cpu_rst_n_o), 64'd1);
   endtask

   typedef struct {
      int lim;
      int mode;
      int poke;
      int halt_at;
      int exp_run;
   } vec_t;

`ifdef RUN_CTRL_EARLY_HALT_EN
   localparam int N_VEC = 7;
`else
   localparam int N_VEC = 6;
`endif
   vec_t vecs [N_VEC];

   initial begin
      vecs[0] = '{lim: 5,  mode: 0, poke: -1, halt_at: -1, exp_run: 5};
      vecs[1] = '{lim: 0,  mode: 0, poke: -1, halt_at: -1, exp_run: 0};
      vecs[2] = '{lim: 3,  mode: 1, poke: -1, halt_at: -1, exp_run: 3};
      vecs[3] = '{lim: 1,  mode: 2, poke: -1, halt_at: -1, exp_run: 1};
      vecs[4] = '{lim: 10, mode: 0, poke: 5,  halt_at: -1, exp_run: 10};
      vecs[5] = '{lim: 4,  mode: 1, poke: 8,  halt_at: -1, exp_run: 4};
`ifdef RUN_CTRL_EARLY_HALT_EN
      vecs[6] = '{lim: 100, mode: 0, poke: 4, halt_at: 8, exp_run: 7};
      halt_i  = 1'b0;
`endif

      rst_i         = 1'b0;
      start_i       = 1'b0;
      dump_ready_i  = 1'b0;
      cycle_limit_i = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_cpu_rst_n", 64'(cpu_rst_n_o), 64'd0);
      chk("rst_cpu_en",    64'(cpu_en_o), 64'd0);
      chk("rst_valid",     64'(dump_valid_o), 64'd0);
      chk("rst_raddr",     64'(dbg_raddr_o), 64'd0);
      chk("rst_addr",      64'(dump_addr_o), 64'd0);
      chk("rst_run_cyc",   64'(run_cycles_o), 64'd0);
      chk("rst_busy",      64'(busy_o), 64'd0);
      chk("rst_done",      64'(done_o), 64'd0);

      // Reset asserted mid-RUN must drop the enable immediately.
      start_i = 1'b1; cycle_limit_i = 16'd50;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (5) @(negedge clk_i);
      chk("midrun_en_pre", 64'(cpu_en_o), 64'd1);
      rst_i = 1'b0;
      #1;
      chk("midrun_en",    64'(cpu_en_o), 64'd0);
      chk("midrun_rstn",  64'(cpu_rst_n_o), 64'd0);
      chk("midrun_busy",  64'(busy_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("midrun_runcyc", 64'(run_cycles_o), 64'd0);
      chk("midrun_valid",  64'(dump_valid_o), 64'd0);

      for (int v = 0; v < N_VEC; v++)
         run_one(vecs[v].lim, vecs[v].mode, vecs[v].poke, vecs[v].halt_at, vecs[v].exp_run);

      // Reset at dump beat 4 discards the partial dump; a new run restarts at r0.
      begin
         logic found = 1'b0;
         start_i = 1'b1; cycle_limit_i = 16'd2;
         @(negedge clk_i);
         start_i      = 1'b0;
         dump_ready_i = 1'b1;
         for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk_i);
            if (dump_valid_o && dump_addr_o == 5'd4) found = 1'b1;
         end
         chk("middump_reach", 64'(found), 64'd1);
         rst_i = 1'b0;
         #1;
         chk("middump_valid", 64'(dump_valid_o), 64'd0);
         chk("middump_busy",  64'(busy_o), 64'd0);
         chk("middump_done",  64'(done_o), 64'd0);
         chk("middump_addr",  64'(dump_addr_o), 64'd0);
         chk("middump_rstn",  64'(cpu_rst_n_o), 64'd0);
         dump_ready_i = 1'b0;
         @(negedge clk_i);
         rst_i = 1'b1;
         repeat (2) @(negedge clk_i);
         run_one(6, 2, -1, -1, 6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
